// File: rtl/quad_decoder_if.sv
// Phase inputs, clear and position outputs of the quadrature decoder.
interface quad_decoder_if #(
    parameter int unsigned COUNT_WIDTH = 4
);
    logic                   a;
    logic                   b;
    logic                   clear;
    logic [COUNT_WIDTH-1:0] count;
    logic                   dir;
    logic                   step;
    logic                   wrap;
    logic                   err;

    modport master (output a, b, clear, input count, dir, step, wrap, err);
    modport slave  (input a, b, clear, output count, dir, step, wrap, err);
endinterface

// File: rtl/quad_decoder.sv
// Quadrature A/B decoder: synchronizer, glitch filter, x4 step decode into a
// wrapping position counter with sticky illegal-transition flag.
module quad_decoder #(
    parameter int unsigned FILTER_LEN  = 2,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    quad_decoder_if.slave qd
);
    localparam int unsigned FCW = 4;

    typedef enum logic {INIT, TRACK} state_t;

    state_t                 state;
    logic [1:0]             sync1;
    logic [1:0]             sync2;
    logic [1:0]             s2_prev;
    logic [1:0]             filt;
    logic [1:0]             fill;
    logic [FCW-1:0]         fcnt;
    logic [FCW-1:0]         fcnt_nxt;
    logic                   differ;
    logic                   accept;
    logic [1:0]             delta;
    logic [COUNT_WIDTH-1:0] count_q;
    logic                   dir_q;
    logic                   step_q;
    logic                   wrap_q;
    logic                   err_q;

    // Gray phase {A,B} to position on the up cycle 00,10,11,01.
    function automatic logic [1:0] phase_pos(input logic [1:0] ab);
        return {ab[0], ab[1] ^ ab[0]};
    endfunction

    // Filter counter next value; INIT accepts any stable value, even one equal to F.
    always_comb begin
        differ   = (state == INIT) || (sync2 != filt);
        fcnt_nxt = '0;
        if (sync2 != s2_prev) begin
            fcnt_nxt = differ ? FCW'(1) : '0;
        end else if (differ) begin
            fcnt_nxt = fcnt + FCW'(1);
        end
        accept = fill[1] && (fcnt_nxt == FCW'(FILTER_LEN));
        delta  = phase_pos(sync2) - phase_pos(filt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= INIT;
            sync1   <= '0;
            sync2   <= '0;
            s2_prev <= '0;
            filt    <= '0;
            fill    <= '0;
            fcnt    <= '0;
            count_q <= '0;
            dir_q   <= 1'b1;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1   <= {qd.a, qd.b};
            sync2   <= sync1;
            s2_prev <= sync2;
            // Filtering waits until s2 holds a real sample rather than the reset fill.
            fill    <= {fill[0], 1'b1};
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            if (fill[1]) begin
                fcnt <= accept ? '0 : fcnt_nxt;
            end
            if (accept) begin
                filt <= sync2;
                if (state == INIT) begin
                    state <= TRACK;
                end else if (!qd.clear) begin
                    unique case (delta)
                        2'b01: begin
                            count_q <= count_q + COUNT_WIDTH'(1);
                            dir_q   <= 1'b1;
                            step_q  <= 1'b1;
                            wrap_q  <= (count_q == '1);
                        end
                        2'b11: begin
                            count_q <= count_q - COUNT_WIDTH'(1);
                            dir_q   <= 1'b0;
                            step_q  <= 1'b1;
                            wrap_q  <= (count_q == '0);
                        end
                        2'b10:   err_q <= 1'b1;
                        default: ;
                    endcase
                end
            end
            if (qd.clear) begin
                count_q <= '0;
                err_q   <= 1'b0;
            end
        end
    end

    assign qd.count = count_q;
    assign qd.dir   = dir_q;
    assign qd.step  = step_q;
    assign qd.wrap  = wrap_q;
    assign qd.err   = err_q;
endmodule
